// File: rtl/coincidence_counter.sv
// rtl/coincidence_counter.sv - per-channel edge counters, N-fold coincidence counter and SPI snapshot readout
//
// Purpose:
//   Counts rising edges on each synchronised hit_in channel. Also counts coincidences:
//   a coincidence is when every channel selected by coinc_mask is armed inside its
//   WIN-cycle window. When spi_ss_n falls, the counts are snapshotted into a shadow
//   register and the live counters are cleared. The shadow is then shifted out MSB-first
//   on spi_miso, one bit per spi_sck falling edge.
//
// Ports:
//   CLK         system clock
//   RST_N       asynchronous active-low reset
//   hit_in      asynchronous channel pulses (NCH)
//   coinc_mask  channels that must be armed together for a coincidence (NCH)
//   spi_sck     SPI clock from host, mode 0, asynchronous
//   spi_ss_n    SPI select, active low, asynchronous
//   spi_miso    serial frame data
//   coinc_out   one-cycle pulse per counted coincidence
//   busy        high while a readout frame is active
//
// Optional feature (macro TIMESTAMP_EN):
//   Adds a free-running 32-bit cycle counter. Its value at snapshot time is prepended
//   to the frame.

module coincidence_counter #(
    parameter int NCH = 4,
    parameter int WIN = 8,
    parameter int CW  = 16
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [NCH-1:0] hit_in,
    input  logic [NCH-1:0] coinc_mask,
    input  logic           spi_sck,
    input  logic           spi_ss_n,
    output logic           spi_miso,
    output logic           coinc_out,
    output logic           busy
);

    localparam int TW = $clog2(WIN + 1);
`ifdef TIMESTAMP_EN
    localparam int FW = 32 + (NCH + 1) * CW;
`else
    localparam int FW = (NCH + 1) * CW;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [NCH-1:0]          hit_s1_q, hit_s1_d, hit_s2_q, hit_s2_d, hit_s3_q, hit_s3_d;
    logic [NCH-1:0]          hp_q, hp_d;
    logic                    sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_s3_q, sck_s3_d;
    logic                    ss_s1_q, ss_s1_d, ss_s2_q, ss_s2_d, ss_s3_q, ss_s3_d;
    logic [NCH-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0][TW-1:0]  tmr_q, tmr_d;
    logic [CW-1:0]           ccnt_q, ccnt_d;
    logic                    lock_q, lock_d;
    logic                    coinc_out_q, coinc_out_d;
    logic [1:0]              state_q, state_d;
    logic [FW-1:0]           shadow_q, shadow_d;
`ifdef TIMESTAMP_EN
    logic [31:0]             ts_q, ts_d;
`endif

    logic [NCH-1:0] armed;
    logic           coinc;
    logic           sck_fall, ss_fall, ss_rise;
    logic [FW-1:0]  frame;

    always_comb begin
        hit_s1_d    = hit_in;
        hit_s2_d    = hit_s1_q;
        hit_s3_d    = hit_s2_q;
        hp_d        = hit_s2_q & ~hit_s3_q;
        sck_s1_d    = spi_sck;
        sck_s2_d    = sck_s1_q;
        sck_s3_d    = sck_s2_q;
        ss_s1_d     = spi_ss_n;
        ss_s2_d     = ss_s1_q;
        ss_s3_d     = ss_s2_q;
        sck_fall    = ~sck_s2_q & sck_s3_q;
        ss_fall     = ~ss_s2_q & ss_s3_q;
        ss_rise     = ss_s2_q & ~ss_s3_q;

        for (int i = 0; i < NCH; i++) begin
            armed[i] = hp_q[i] | (tmr_q[i] != '0);
            if (hp_q[i])
                tmr_d[i] = TW'(WIN);
            else if (tmr_q[i] != '0)
                tmr_d[i] = tmr_q[i] - 1'b1;
            else
                tmr_d[i] = tmr_q[i];
            if (hp_q[i] && (cnt_q[i] != {CW{1'b1}}))
                cnt_d[i] = cnt_q[i] + 1'b1;
            else
                cnt_d[i] = cnt_q[i];
        end

        // Unmasked channels are forced "armed" so that only masked ones gate.
        // The lock stops re-counting while the same overlap persists.
        coinc = (coinc_mask != '0) && (&(armed | ~coinc_mask))
                && (|(hp_q & coinc_mask)) && !lock_q;

        ccnt_d = (coinc && (ccnt_q != {CW{1'b1}})) ? ccnt_q + 1'b1 : ccnt_q;

        if (coinc)
            lock_d = 1'b1;
        else if (|(coinc_mask & ~armed))
            lock_d = 1'b0;
        else
            lock_d = lock_q;

        coinc_out_d = coinc;

`ifdef TIMESTAMP_EN
        ts_d  = ts_q + 32'd1;
        frame = {ts_q, ccnt_q, cnt_q};
`else
        frame = {ccnt_q, cnt_q};
`endif

        state_d  = state_q;
        shadow_d = shadow_q;
        case (state_q)
            S_IDLE: begin
                if (ss_fall)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                shadow_d = frame;
                // Restart the live counters from this cycle's events so nothing is lost.
                for (int i = 0; i < NCH; i++)
                    cnt_d[i] = {{(CW-1){1'b0}}, hp_q[i]};
                ccnt_d = {{(CW-1){1'b0}}, coinc};
                if (ss_rise) begin
                    state_d  = S_IDLE;
                    shadow_d = '0;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ss_rise) begin
                    state_d  = S_IDLE;
                    shadow_d = '0;
                end else if (sck_fall) begin
                    shadow_d = {shadow_q[FW-2:0], 1'b0};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hit_s1_q    <= '0;
            hit_s2_q    <= '0;
            hit_s3_q    <= '0;
            hp_q        <= '0;
            sck_s1_q    <= 1'b0;
            sck_s2_q    <= 1'b0;
            sck_s3_q    <= 1'b0;
            ss_s1_q     <= 1'b1;
            ss_s2_q     <= 1'b1;
            ss_s3_q     <= 1'b1;
            cnt_q       <= '0;
            tmr_q       <= '0;
            ccnt_q      <= '0;
            lock_q      <= 1'b0;
            coinc_out_q <= 1'b0;
            state_q     <= S_IDLE;
            shadow_q    <= '0;
`ifdef TIMESTAMP_EN
            ts_q        <= '0;
`endif
        end else begin
            hit_s1_q    <= hit_s1_d;
            hit_s2_q    <= hit_s2_d;
            hit_s3_q    <= hit_s3_d;
            hp_q        <= hp_d;
            sck_s1_q    <= sck_s1_d;
            sck_s2_q    <= sck_s2_d;
            sck_s3_q    <= sck_s3_d;
            ss_s1_q     <= ss_s1_d;
            ss_s2_q     <= ss_s2_d;
            ss_s3_q     <= ss_s3_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            ccnt_q      <= ccnt_d;
            lock_q      <= lock_d;
            coinc_out_q <= coinc_out_d;
            state_q     <= state_d;
            shadow_q    <= shadow_d;
`ifdef TIMESTAMP_EN
            ts_q        <= ts_d;
`endif
        end
    end

    assign spi_miso  = (state_q == S_SHIFT) & shadow_q[FW-1];
    assign busy      = (state_q != S_IDLE);
    assign coinc_out = coinc_out_q;

endmodule
